// File: rtl/tuning_pkg.sv
// rtl/tuning_pkg.sv - shared types, step table and saturating add for the tuning controller
package tuning_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    APPLY = 2'd2,
    SEND  = 2'd3
  } state_t;

  localparam int NUM_STEPS = 6;

  // Entry 0 is the finest step (1 Hz), entry 5 the coarsest (100 kHz).
  localparam logic [NUM_STEPS-1:0][31:0] STEP = {
    32'd100_000, 32'd10_000, 32'd1_000, 32'd100, 32'd10, 32'd1
  };

  function automatic logic [31:0] step_hz(input logic [2:0] idx);
    return (idx < 3'(NUM_STEPS)) ? STEP[idx] : 32'd1;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {a[7], a} + {b[7], b};
    if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7f;
    return s[7:0];
  endfunction

endpackage

// File: rtl/tuning_if.sv
// rtl/tuning_if.sv - frequency word valid/ready handshake toward the synth control path
interface tuning_if #(
  parameter int FQ_W = 32
);
  logic [FQ_W-1:0] fq_out;
  logic            fq_valid;
  logic            fq_ready;

  modport master (output fq_out, output fq_valid, input fq_ready);
  modport slave  (input fq_out, input fq_valid, output fq_ready);
endinterface

// File: rtl/tuning_mul.sv
// rtl/tuning_mul.sv - 8 x FQ_W serial shift-add multiplier, LSB first, done 8 cycles after start
module tuning_mul #(
  parameter int FQ_W = 32
) (
  input  logic            aclk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      operand_a,
  input  logic [FQ_W-1:0] operand_b,
  output logic            done,
  output logic [FQ_W-1:0] product
);

  logic [7:0]      a_sh;
  logic [FQ_W-1:0] b_sh;
  logic [FQ_W-1:0] acc;
  logic [2:0]      cnt;
  logic            running;

  // The first partial product is folded into the start cycle so the eighth lands one cycle before done.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc     <= operand_a[0] ? operand_b : '0;
        a_sh    <= {1'b0, operand_a[7:1]};
        b_sh    <= {operand_b[FQ_W-2:0], 1'b0};
        cnt     <= 3'd1;
        running <= 1'b1;
      end else if (running) begin
        if (a_sh[0]) acc <= acc + b_sh;
        a_sh <= {1'b0, a_sh[7:1]};
        b_sh <= {b_sh[FQ_W-2:0], 1'b0};
        cnt  <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/tuning_ctrl.sv
// rtl/tuning_ctrl.sv - dial/preset tuning controller with step scaling, band clamp and handshake
module tuning_ctrl
  import tuning_pkg::*;
#(
  parameter int              FQ_W      = 32,
  parameter logic [FQ_W-1:0] FQ_MIN    = 100_000,
  parameter logic [FQ_W-1:0] FQ_MAX    = 30_000_000,
  parameter logic [FQ_W-1:0] FQ_INIT   = 7_000_000,
  parameter logic [2:0]      STEP_INIT = 3'd3
) (
  input  logic            aclk,
  input  logic            reset,
  input  logic            inc_valid,
  input  logic [7:0]      inc,
  input  logic            step_btn,
  input  logic            preset_load,
  input  logic [FQ_W-1:0] preset_fq,
  tuning_if.master        fq_if,
  output logic [2:0]      step_idx,
  output logic            busy
);

  state_t state, state_n;

  logic            inc_valid_d;
  logic            inc_edge;
  logic [FQ_W-1:0] fq_q;

  logic [7:0]      pend_inc, pend_inc_n;
  logic            pend_inc_flag, pend_inc_flag_n;
  logic            pend_pre_flag, pend_pre_flag_n;
  logic [FQ_W-1:0] pend_pre_val, pend_pre_val_n;

  logic            op_preset, op_neg;
  logic [FQ_W-1:0] op_val;

  logic            idle;
  logic            svc_pend_pre, svc_pre, svc_pend_inc, svc_inc;
  logic            svc_any_pre, svc_any_inc;
  logic [7:0]      sel_inc;
  logic [7:0]      mul_a;
  logic            mul_start, mul_done;
  logic [FQ_W-1:0] delta;

  logic [FQ_W:0]   sum_w, room_w;
  logic [FQ_W-1:0] apply_fq;

  assign inc_edge = inc_valid & ~inc_valid_d & (inc != 8'd0);
  assign idle     = (state == IDLE);

  // Service priority in IDLE: pending preset, new preset, pending increment, new increment.
  assign svc_pend_pre = idle & pend_pre_flag;
  assign svc_pre      = idle & ~pend_pre_flag & preset_load;
  assign svc_pend_inc = idle & ~pend_pre_flag & ~preset_load & pend_inc_flag;
  assign svc_inc      = idle & ~pend_pre_flag & ~preset_load & ~pend_inc_flag & inc_edge;
  assign svc_any_pre  = svc_pend_pre | svc_pre;
  assign svc_any_inc  = svc_pend_inc | svc_inc;

  assign sel_inc = svc_pend_inc ? pend_inc : inc;
  assign mul_a   = sel_inc[7] ? (~sel_inc + 8'd1) : sel_inc;

  tuning_mul #(.FQ_W(FQ_W)) u_mul (
    .aclk      (aclk),
    .reset     (reset),
    .start     (mul_start),
    .operand_a (mul_a),
    .operand_b (FQ_W'(step_hz(step_idx))),
    .done      (mul_done),
    .product   (delta)
  );

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) state <= SEND;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (svc_any_pre)      state_n = APPLY;
        else if (svc_any_inc) state_n = MULT;
      end
      MULT:    if (mul_done) state_n = APPLY;
      APPLY:   state_n = (apply_fq == fq_q) ? IDLE : SEND;
      SEND:    if (fq_if.fq_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    fq_if.fq_valid = (state == SEND);
    mul_start      = svc_any_inc;
  end

  // Band arithmetic is one bit wider than the word so sums and differences never wrap.
  always_comb begin
    sum_w    = {1'b0, fq_q} + {1'b0, delta};
    room_w   = {1'b0, fq_q} - {1'b0, FQ_MIN};
    apply_fq = fq_q;
    if (op_preset) begin
      if (op_val < FQ_MIN)      apply_fq = FQ_MIN;
      else if (op_val > FQ_MAX) apply_fq = FQ_MAX;
      else                      apply_fq = op_val;
    end else if (!op_neg) begin
      apply_fq = (sum_w > {1'b0, FQ_MAX}) ? FQ_MAX : sum_w[FQ_W-1:0];
    end else begin
      apply_fq = ({1'b0, delta} > room_w) ? FQ_MIN : (fq_q - delta);
    end
  end

  // Unserviced events are coalesced; a preset discards any increment queued before it.
  always_comb begin
    pend_inc_n      = pend_inc;
    pend_inc_flag_n = pend_inc_flag;
    pend_pre_flag_n = pend_pre_flag;
    pend_pre_val_n  = pend_pre_val;
    if (svc_pend_inc) begin
      pend_inc_n      = 8'd0;
      pend_inc_flag_n = 1'b0;
    end
    if (svc_pend_pre) pend_pre_flag_n = 1'b0;
    if (preset_load && !svc_pre) begin
      pend_pre_flag_n = 1'b1;
      pend_pre_val_n  = preset_fq;
      pend_inc_n      = 8'd0;
      pend_inc_flag_n = 1'b0;
    end
    if (inc_edge && !svc_inc) begin
      pend_inc_n      = sat_add8(pend_inc_n, inc);
      pend_inc_flag_n = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      fq_q          <= FQ_INIT;
      step_idx      <= STEP_INIT;
      inc_valid_d   <= 1'b0;
      pend_inc      <= 8'd0;
      pend_inc_flag <= 1'b0;
      pend_pre_flag <= 1'b0;
      pend_pre_val  <= '0;
      op_preset     <= 1'b0;
      op_neg        <= 1'b0;
      op_val        <= '0;
      busy          <= 1'b1;
    end else begin
      inc_valid_d   <= inc_valid;
      pend_inc      <= pend_inc_n;
      pend_inc_flag <= pend_inc_flag_n;
      pend_pre_flag <= pend_pre_flag_n;
      pend_pre_val  <= pend_pre_val_n;
      busy          <= (state_n != IDLE);
      if (step_btn)
        step_idx <= (step_idx == 3'(NUM_STEPS - 1)) ? 3'd0 : step_idx + 3'd1;
      if (svc_any_pre) begin
        op_preset <= 1'b1;
        op_val    <= svc_pend_pre ? pend_pre_val : preset_fq;
      end else if (svc_any_inc) begin
        op_preset <= 1'b0;
        op_neg    <= sel_inc[7];
      end
      if (state == APPLY && state_n == SEND) fq_q <= apply_fq;
    end
  end

  assign fq_if.fq_out = fq_q;

endmodule

// File: tb/tb_tuning_ctrl.sv
// tb/tb_tuning_ctrl.sv - directed table-driven bench for tuning_ctrl
module tb_tuning_ctrl;

  logic        aclk = 1'b0;
  logic        reset = 1'b0;
  logic        inc_valid = 1'b0;
  logic [7:0]  inc = 8'd0;
  logic        step_btn = 1'b0;
  logic        preset_load = 1'b0;
  logic [31:0] preset_fq = 32'd0;
  logic [2:0]  step_idx;
  logic        busy;

  tuning_if #(.FQ_W(32)) fq_if ();

  tuning_ctrl dut (
    .aclk        (aclk),
    .reset       (reset),
    .inc_valid   (inc_valid),
    .inc         (inc),
    .step_btn    (step_btn),
    .preset_load (preset_load),
    .preset_fq   (preset_fq),
    .fq_if       (fq_if),
    .step_idx    (step_idx),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_pre;
    logic [7:0]  inc;
    logic [31:0] pre;
    int          presses;
    logic [2:0]  idx;
    logic [31:0] fq;
    bit          send;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int lat;
    for (int p = 0; p < v.presses; p++) begin
      step_btn = 1'b1;
      tick();
      step_btn = 1'b0;
    end
    chk($sformatf("v%0d_step_idx", i), 64'(step_idx), 64'(v.idx));
    if (v.is_pre) begin
      preset_load = 1'b1;
      preset_fq   = v.pre;
      lat = 2;
    end else begin
      inc_valid = 1'b1;
      inc       = v.inc;
      lat = 10;
    end
    tick();
    preset_load = 1'b0;
    inc_valid   = 1'b0;
    for (int k = 1; k < lat - 1; k++) tick();
    chk($sformatf("v%0d_valid_early", i), 64'(fq_if.fq_valid), 64'd0);
    tick();
    chk($sformatf("v%0d_valid", i), 64'(fq_if.fq_valid), 64'(v.send));
    chk($sformatf("v%0d_fq", i), 64'(fq_if.fq_out), 64'(v.fq));
    if (v.send) begin
      fq_if.fq_ready = 1'b1;
      tick();
      fq_if.fq_ready = 1'b0;
      chk($sformatf("v%0d_valid_drop", i), 64'(fq_if.fq_valid), 64'd0);
    end
    chk($sformatf("v%0d_busy_low", i), 64'(busy), 64'd0);
  endtask

  initial begin
    fq_if.fq_ready = 1'b0;

    vt[0]  = '{0, 8'd5,   32'd0,          0, 3'd3, 32'd7_005_000,  1'b1};
    vt[1]  = '{0, 8'hFD,  32'd0,          2, 3'd5, 32'd6_705_000,  1'b1};
    vt[2]  = '{1, 8'd0,   32'd29_950_000, 0, 3'd5, 32'd29_950_000, 1'b1};
    vt[3]  = '{0, 8'h7F,  32'd0,          0, 3'd5, 32'd30_000_000, 1'b1};
    vt[4]  = '{0, 8'd1,   32'd0,          0, 3'd5, 32'd30_000_000, 1'b0};
    vt[5]  = '{1, 8'd0,   32'd50_000,     0, 3'd5, 32'd100_000,    1'b1};
    vt[6]  = '{0, 8'hFF,  32'd0,          0, 3'd5, 32'd100_000,    1'b0};
    vt[7]  = '{0, 8'h7F,  32'd0,          1, 3'd0, 32'd100_127,    1'b1};
    vt[8]  = '{0, 8'h80,  32'd0,          0, 3'd0, 32'd100_000,    1'b1};
    vt[9]  = '{1, 8'd0,   32'd40_000_000, 0, 3'd0, 32'd30_000_000, 1'b1};
    vt[10] = '{0, 8'hCE,  32'd0,          3, 3'd3, 32'd29_950_000, 1'b1};
    vt[11] = '{1, 8'd0,   32'd1_000_000,  0, 3'd3, 32'd1_000_000,  1'b1};

    #3 reset = 1'b1;
    #2;
    chk("rst_fq", 64'(fq_if.fq_out), 64'd7_000_000);
    chk("rst_valid", 64'(fq_if.fq_valid), 64'd1);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_step_idx", 64'(step_idx), 64'd3);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("init_stall_valid", 64'(fq_if.fq_valid), 64'd1);
    end
    fq_if.fq_ready = 1'b1;
    tick();
    fq_if.fq_ready = 1'b0;
    chk("init_xfer_valid", 64'(fq_if.fq_valid), 64'd0);
    chk("init_xfer_busy", 64'(busy), 64'd0);

    foreach (vt[i]) run_vec(vt[i], i);

    // Increments arriving during a stalled SEND saturate to +127.
    inc_valid = 1'b1;
    inc = 8'd1;
    tick();
    inc_valid = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    chk("sat_first_valid", 64'(fq_if.fq_valid), 64'd1);
    chk("sat_first_fq", 64'(fq_if.fq_out), 64'd1_001_000);
    for (int e = 0; e < 3; e++) begin
      inc_valid = 1'b1;
      inc = 8'd100;
      tick();
      inc_valid = 1'b0;
      tick();
    end
    chk("sat_stall_valid", 64'(fq_if.fq_valid), 64'd1);
    chk("sat_stall_fq", 64'(fq_if.fq_out), 64'd1_001_000);
    fq_if.fq_ready = 1'b1;
    tick();
    fq_if.fq_ready = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    chk("sat_pend_early", 64'(fq_if.fq_valid), 64'd0);
    tick();
    chk("sat_pend_valid", 64'(fq_if.fq_valid), 64'd1);
    chk("sat_pend_fq", 64'(fq_if.fq_out), 64'd1_128_000);
    fq_if.fq_ready = 1'b1;
    tick();
    fq_if.fq_ready = 1'b0;
    chk("sat_busy_low", 64'(busy), 64'd0);

    // Preset during MULT, then +2, with fq_ready held once the first SEND appears.
    inc_valid = 1'b1;
    inc = 8'd10;
    for (int k = 1; k <= 25; k++) begin
      tick();
      inc_valid   = (k == 5);
      inc         = (k == 5) ? 8'd2 : 8'd10;
      preset_load = (k == 3);
      preset_fq   = 32'd14_200_000;
      chk($sformatf("pq_valid_c%0d", k), 64'(fq_if.fq_valid),
          64'((k == 10) || (k == 13) || (k == 24)));
      if (k == 10) begin
        chk("pq_first_fq", 64'(fq_if.fq_out), 64'd1_138_000);
        fq_if.fq_ready = 1'b1;
      end
      if (k == 13) chk("pq_preset_fq", 64'(fq_if.fq_out), 64'd14_200_000);
      if (k == 24) chk("pq_inc_fq", 64'(fq_if.fq_out), 64'd14_202_000);
    end
    inc_valid   = 1'b0;
    preset_load = 1'b0;
    fq_if.fq_ready = 1'b0;
    chk("pq_busy_low", 64'(busy), 64'd0);

    // Reset asserted while the multiplier is running.
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    chk("mr_step_idx", 64'(step_idx), 64'd4);
    inc_valid = 1'b1;
    inc = 8'd7;
    tick();
    inc_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mr_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("mr_rst_fq", 64'(fq_if.fq_out), 64'd7_000_000);
    chk("mr_rst_valid", 64'(fq_if.fq_valid), 64'd1);
    chk("mr_rst_busy", 64'(busy), 64'd1);
    chk("mr_rst_step_idx", 64'(step_idx), 64'd3);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("mr_hold_valid", 64'(fq_if.fq_valid), 64'd1);
      chk("mr_hold_fq", 64'(fq_if.fq_out), 64'd7_000_000);
    end
    fq_if.fq_ready = 1'b1;
    tick();
    chk("mr_xfer_valid", 64'(fq_if.fq_valid), 64'd0);
    chk("mr_xfer_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("mr_no_stale", 64'(fq_if.fq_valid), 64'd0);
    end
    chk("mr_final_fq", 64'(fq_if.fq_out), 64'd7_000_000);
    fq_if.fq_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tuning_ctrl.md
# tuning_ctrl

Frequency tuning controller between the front-panel frequency dial and the synthesizer frequency register. Consumes signed dial increments and single-cycle step-button pulses, scales each increment by the selected step size with a serial shift-add multiplier, adds it to the current frequency and clamps the result to a legal band. Each new frequency is presented to the downstream synth control path through a valid/ready handshake. Increments and presets that arrive while a computation is in flight are coalesced, never dropped.

## Interface
Parameters:
- FQ_W, 32, frequency word width in Hz.
- FQ_MIN, 100_000, lowest legal frequency.
- FQ_MAX, 30_000_000, highest legal frequency.
- FQ_INIT, 7_000_000, frequency after reset.
- STEP_INIT, 3, step-table index after reset (1 kHz).

Ports:
- aclk  in  1  system clock
- reset  in  1  asynchronous, active-high master reset
- inc_valid  in  1  dial output-valid level; a rising edge marks a new increment
- inc  in  8  signed two's-complement dial increment, sampled on the inc_valid rising edge
- step_btn  in  1  debounced single-cycle pulse that advances the step index
- preset_load  in  1  single-cycle pulse that loads preset_fq
- preset_fq  in  FQ_W  preset frequency, sampled when preset_load is high
- fq_out  out  FQ_W  current frequency
- fq_valid  out  1  fq_out offered downstream
- fq_ready  in  1  downstream accepts fq_out
- step_idx  out  3  current step index, for the display
- busy  out  1  state != IDLE

## Operation
- Step table, index 0..5: 1, 10, 100, 1_000, 10_000, 100_000 Hz.
- step_btn behaviour:
  - Increments step_idx in any state; wraps from 5 to 0.
  - step_idx is sampled into the multiplier when MULT is entered.
- Edge detection: inc_valid is registered into inc_valid_d. A rising edge is inc_valid & ~inc_valid_d. An edge with inc == 0 is ignored.
- FSM states: IDLE, MULT, APPLY, SEND.
- IDLE services sources in priority order:
  1. pending preset
  2. preset_load
  3. pending increment
  4. new inc edge
  - An inc edge coinciding with a serviced preset goes to the pending increment.
- MULT:
  - Computes delta = |inc| × STEP[idx] with an unsigned serial shift-add, LSB first, 8 cycles.
  - delta fits in 27 bits; it is held in FQ_W bits.
- APPLY, computed in FQ_W+1 bits:
  - Positive increment: fq+delta; if above FQ_MAX the result is FQ_MAX.
  - Negative increment: if delta > fq−FQ_MIN the result is FQ_MIN, else fq−delta.
  - Preset: the value is clamped to [FQ_MIN, FQ_MAX].
  - If the result equals fq_out, go to IDLE without SEND. Otherwise update fq_out and go to SEND.
- SEND:
  - fq_valid stays high and fq_out stays stable until fq_valid & fq_ready, then go to IDLE.
- Coalescing while state != IDLE:
  - Inc edges are summed into pending_inc, saturating at −128/+127, and pending_inc_flag is set.
  - preset_load latches into the pending preset (last one wins) and clears the pending increment.
- Asynchronous reset, including mid-operation:
  - fq_out=FQ_INIT, step_idx=STEP_INIT.
  - State=SEND with fq_valid=1, so the initial frequency is always delivered.
  - All pending state and inc_valid_d are cleared; busy=1.

## Timing
- Cycle N is the IDLE cycle in which an inc edge is accepted.
- Increment path:
  - MULT occupies N+1..N+8; APPLY is N+9.
  - fq_out is updated and fq_valid is high from N+10. Latency is 10 cycles.
- Preset path: APPLY at N+1, fq_valid at N+2.
- Handshake:
  - Transfer occurs on the first edge where fq_valid & fq_ready.
  - fq_ready may be held high permanently.
  - The earliest next service is in IDLE, the cycle after the transfer.
- A pending item is serviced on the first IDLE cycle. Its latency is measured from that cycle.
- busy is registered and equals (state != IDLE).

## Structure
- Package tuning_pkg holds:
  - the state enum
  - NUM_STEPS=6
  - the STEP table constant
  - the saturating 8-bit add function
- Sub-module tuning_mul: 8×FQ_W serial shift-add multiplier.
  - Interface: start, done, operand_a[7:0], operand_b[FQ_W-1:0], product.
  - done pulses exactly 8 cycles after start.

## Test plan
- After reset: fq_out=7_000_000 and fq_valid=1. Hold fq_ready=0 for 5 cycles: fq_valid stays 1. Assert fq_ready: transfer, busy falls.
- inc=+5 at step 3: fq_valid rises 10 cycles after the edge with fq_out=7_005_000. Then inc=−3 with step_btn ×2 (index 5): fq_out=6_705_000.
- Clamp cases at step 5 from 29_950_000:
  - inc=+127: fq_out=30_000_000.
  - A further +1: no SEND, busy returns low.
  - A preset of 50_000: fq_out=100_000.
- Three inc edges of +100 while SEND is stalled: pending_inc saturates at 127, and one update of +127×STEP follows.
- preset_load=14_200_000 during MULT, followed by inc=+2 during the same busy period: after the current SEND, the preset is delivered, then +2 is applied.
- Assert reset during MULT: outputs return to their reset values immediately (asynchronously), no stale SEND occurs, and step_idx=3.
